// File: rtl/elastic_context_controller.sv
// Context sequencer for one elastic PE: holds a table of {op, const} contexts and steps through it on ALU switch_context pulses.
// Optional pass limit with a DONE state is enabled by defining ELASTIC_CONTEXT_LOOP_LIMIT_EN.
module elastic_context_controller #(
  parameter int DATA_WIDTH           = 32,
  parameter int OPERATION_BIT_LENGTH = 4,
  parameter int CONTEXT_NUM          = 8,
  parameter int CTX_ADDR_WIDTH       = 3,
  parameter int LOOP_WIDTH           = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            config_write,
  input  logic [CTX_ADDR_WIDTH-1:0]       config_addr,
  input  logic [OPERATION_BIT_LENGTH-1:0] config_op,
  input  logic [DATA_WIDTH-1:0]           config_const,
  input  logic [CTX_ADDR_WIDTH:0]         config_context_num,
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
  input  logic [LOOP_WIDTH-1:0]           config_loop_limit,
`endif
  input  logic                            start,
  input  logic                            abort,
  input  logic                            switch_context,
  output logic [OPERATION_BIT_LENGTH-1:0] op,
  output logic [DATA_WIDTH-1:0]           const_data,
  output logic                            start_exec,
  output logic [CTX_ADDR_WIDTH-1:0]       context_id,
  output logic [LOOP_WIDTH-1:0]           iteration_count,
  output logic                            running,
  output logic                            done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CTX_ADDR_WIDTH:0] CTX_NUM_MAX = (CTX_ADDR_WIDTH+1)'(CONTEXT_NUM);

  state_t                            state_reg, state_next;
  logic [CTX_ADDR_WIDTH-1:0]         context_id_reg, context_id_next;
  logic [LOOP_WIDTH-1:0]             iteration_reg, iteration_next;
  logic [CTX_ADDR_WIDTH:0]           num_ctx_reg, num_ctx_next;
  logic                              start_exec_reg, start_exec_next;
  logic [OPERATION_BIT_LENGTH-1:0]   op_table_reg    [CONTEXT_NUM];
  logic [DATA_WIDTH-1:0]             const_table_reg [CONTEXT_NUM];

  logic                  cfg_window;
  logic                  start_ok;
  logic                  last_ctx;
  logic [LOOP_WIDTH-1:0] iteration_inc;

  assign cfg_window    = (state_reg != RUN);
  assign start_ok      = cfg_window && start && !abort &&
                         (config_context_num != '0) && (config_context_num <= CTX_NUM_MAX);
  assign last_ctx      = ({1'b0, context_id_reg} == (num_ctx_reg - 1'b1));
  assign iteration_inc = iteration_reg + 1'b1;

`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
  logic [LOOP_WIDTH-1:0] loop_limit_reg, loop_limit_next;
`endif

  // Addresses at or beyond CONTEXT_NUM match no entry, so such writes fall away.
  generate
    for (genvar gi = 0; gi < CONTEXT_NUM; gi++) begin : g_table
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          op_table_reg[gi]    <= '0;
          const_table_reg[gi] <= '0;
        end else if (cfg_window && config_write &&
                     ({1'b0, config_addr} == (CTX_ADDR_WIDTH+1)'(gi))) begin
          op_table_reg[gi]    <= config_op;
          const_table_reg[gi] <= config_const;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      context_id_reg <= '0;
      iteration_reg  <= '0;
      num_ctx_reg    <= '0;
      start_exec_reg <= 1'b0;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
      loop_limit_reg <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      context_id_reg <= context_id_next;
      iteration_reg  <= iteration_next;
      num_ctx_reg    <= num_ctx_next;
      start_exec_reg <= start_exec_next;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
      loop_limit_reg <= loop_limit_next;
`endif
    end
  end

  // Priority: abort, then an accepted start, then switch_context while running.
  always_comb begin
    state_next      = state_reg;
    context_id_next = context_id_reg;
    iteration_next  = iteration_reg;
    num_ctx_next    = num_ctx_reg;
    start_exec_next = 1'b0;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
    loop_limit_next = loop_limit_reg;
`endif
    if (abort) begin
      state_next      = IDLE;
      context_id_next = '0;
    end else if (start_ok) begin
      state_next      = RUN;
      context_id_next = '0;
      iteration_next  = '0;
      num_ctx_next    = config_context_num;
      start_exec_next = 1'b1;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
      loop_limit_next = config_loop_limit;
`endif
    end else if ((state_reg == RUN) && switch_context) begin
      if (last_ctx) begin
        context_id_next = '0;
        iteration_next  = iteration_inc;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
        // A zero limit never matches, so the run is unbounded.
        if ((loop_limit_reg != '0) && (iteration_inc == loop_limit_reg)) begin
          state_next = DONE;
        end
`endif
      end else begin
        context_id_next = context_id_reg + 1'b1;
      end
    end
  end

  assign op              = (state_reg == RUN) ? op_table_reg[context_id_reg]    : '0;
  assign const_data      = (state_reg == RUN) ? const_table_reg[context_id_reg] : '0;
  assign start_exec      = start_exec_reg;
  assign context_id      = context_id_reg;
  assign iteration_count = iteration_reg;
  assign running         = (state_reg == RUN);
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
  assign done            = (state_reg == DONE);
`else
  assign done            = 1'b0;
`endif

endmodule

// File: tb/tb_elastic_context_controller.sv
// Scoreboard bench for elastic_context_controller: expected output snapshots are queued as stimulus is driven
// and compared one cycle later, one line per transaction.
module tb_elastic_context_controller;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] cst;
    logic [2:0]  ctx;
    logic [15:0] iter;
    logic        run;
    logic        dn;
    logic        sx;
  } snap_t;

  typedef struct {
    string       nm;
    logic        wr;
    logic [2:0]  a;
    logic [3:0]  wop;
    logic [31:0] wc;
    logic        st;
    logic [3:0]  n;
    logic        ab;
    logic        sw;
    logic [15:0] lim;
    snap_t       exp;
  } row_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        config_write = 1'b0;
  logic [2:0]  config_addr = '0;
  logic [3:0]  config_op = '0;
  logic [31:0] config_const = '0;
  logic [3:0]  config_context_num = '0;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
  logic [15:0] config_loop_limit = '0;
`endif
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        switch_context = 1'b0;
  logic [3:0]  op;
  logic [31:0] const_data;
  logic        start_exec;
  logic [2:0]  context_id;
  logic [15:0] iteration_count;
  logic        running;
  logic        done;

  snap_t obs;
  assign obs = {op, const_data, context_id, iteration_count, running, done, start_exec};

  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];
  string name_q[$];
  logic [3:0]  m_op  [8];
  logic [31:0] m_cst [8];

  always #5 clk = ~clk;

  elastic_context_controller dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .config_write      (config_write),
    .config_addr       (config_addr),
    .config_op         (config_op),
    .config_const      (config_const),
    .config_context_num(config_context_num),
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
    .config_loop_limit (config_loop_limit),
`endif
    .start             (start),
    .abort             (abort),
    .switch_context    (switch_context),
    .op                (op),
    .const_data        (const_data),
    .start_exec        (start_exec),
    .context_id        (context_id),
    .iteration_count   (iteration_count),
    .running           (running),
    .done              (done)
  );

  function automatic snap_t run_at(input int c, input logic [15:0] it, input logic sx);
    return {m_op[c], m_cst[c], 3'(c), it, 1'b1, 1'b0, sx};
  endfunction

  function automatic snap_t idle_at(input int c, input logic [15:0] it);
    return {4'd0, 32'd0, 3'(c), it, 1'b0, 1'b0, 1'b0};
  endfunction

  function automatic snap_t done_at(input logic [15:0] it);
    return {4'd0, 32'd0, 3'd0, it, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic row_t mk(input string nm, input logic wr, input logic [2:0] a,
                              input logic [3:0] wop, input logic [31:0] wc, input logic st,
                              input logic [3:0] n, input logic ab, input logic sw,
                              input snap_t e, input logic [15:0] lim = 16'd0);
    row_t r;
    r.nm = nm; r.wr = wr; r.a = a; r.wop = wop; r.wc = wc; r.st = st;
    r.n = n; r.ab = ab; r.sw = sw; r.lim = lim; r.exp = e;
    return r;
  endfunction

  task automatic drive(input row_t r);
    config_write = r.wr;
    config_addr = r.a;
    config_op = r.wop;
    config_const = r.wc;
    start = r.st;
    config_context_num = r.n;
    abort = r.ab;
    switch_context = r.sw;
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
    config_loop_limit = r.lim;
`endif
    @(posedge clk);
    #1;
    config_write = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    switch_context = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    snap_t e;
    string nm;
    for (int i = 0; i < 8; i++) begin m_op[i] = '0; m_cst[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(idle_at(0, 0)); name_q.push_back("reset_state");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    else $display("ok   %s: %h", nm, obs);
    @(negedge clk) reset_n = 1'b1;
    m_op[0] = 4'd1; m_cst[0] = 32'd0;
    m_op[1] = 4'd5; m_cst[1] = 32'd7;
    m_op[2] = 4'd8; m_cst[2] = 32'd0;
    rows.push_back(mk("idle_write0", 1, 3'd0, 4'd1, 32'd0, 0, 4'd0, 0, 0, idle_at(0, 0)));
    rows.push_back(mk("idle_write1", 1, 3'd1, 4'd5, 32'd7, 0, 4'd0, 0, 0, idle_at(0, 0)));
    rows.push_back(mk("idle_write2", 1, 3'd2, 4'd8, 32'd0, 0, 4'd0, 0, 0, idle_at(0, 0)));
    rows.push_back(mk("idle_nop_op0", 0, 3'd0, 4'd0, 32'd0, 0, 4'd0, 0, 0, idle_at(0, 0)));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask

  task automatic test_sequence();
    row_t rows[$];
    snap_t e;
    string nm;
    rows.push_back(mk("start_exec_pulse", 0, 3'd0, 4'd0, 32'd0, 1, 4'd3, 0, 0, run_at(0, 0, 1)));
    rows.push_back(mk("run_hold_ctx0",    0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 0, run_at(0, 0, 0)));
    rows.push_back(mk("switch_to_ctx1",   0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 1, run_at(1, 0, 0)));
    rows.push_back(mk("switch_to_ctx2",   0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 1, run_at(2, 0, 0)));
    rows.push_back(mk("switch_wrap",      0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 1, run_at(0, 1, 0)));
    rows.push_back(mk("run_hold_iter1",   0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 0, run_at(0, 1, 0)));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask

  task automatic test_run_guard();
    row_t rows[$];
    snap_t e;
    string nm;
    rows.push_back(mk("run_switch_ctx1",   0, 3'd0, 4'd0, 32'd0,  0, 4'd3, 0, 0, run_at(0, 1, 0)));
    rows[0].sw = 1'b1;
    rows[0].exp = run_at(1, 1, 0);
    rows.push_back(mk("run_write_ignored", 1, 3'd1, 4'd3, 32'h33, 0, 4'd3, 0, 0, run_at(1, 1, 0)));
    rows.push_back(mk("run_start_ignored", 0, 3'd0, 4'd0, 32'd0,  1, 4'd2, 0, 0, run_at(1, 1, 0)));
    rows.push_back(mk("abort_beats_start", 0, 3'd0, 4'd0, 32'd0,  1, 4'd2, 1, 0, idle_at(0, 1)));
    rows.push_back(mk("idle_switch_ign",   0, 3'd0, 4'd0, 32'd0,  0, 4'd2, 0, 1, idle_at(0, 1)));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask

  task automatic test_bad_start();
    row_t rows[$];
    snap_t e;
    string nm;
    rows.push_back(mk("start_num0_ign",  0, 3'd0, 4'd0, 32'd0, 1, 4'd0,  0, 0, idle_at(0, 1)));
    rows.push_back(mk("start_num9_ign",  0, 3'd0, 4'd0, 32'd0, 1, 4'd9,  0, 0, idle_at(0, 1)));
    rows.push_back(mk("start_num15_ign", 0, 3'd0, 4'd0, 32'd0, 1, 4'd15, 0, 0, idle_at(0, 1)));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask

  task automatic test_write_start();
    row_t rows[$];
    snap_t e;
    string nm;
    m_op[0] = 4'd9; m_cst[0] = 32'h55;
    rows.push_back(mk("write_with_start", 1, 3'd0, 4'd9, 32'h55, 1, 4'd8, 0, 0, run_at(0, 0, 1)));
    for (int c = 1; c < 8; c++)
      rows.push_back(mk("b2b_switch_num8", 0, 3'd0, 4'd0, 32'd0, 0, 4'd8, 0, 1, run_at(c, 0, 0)));
    rows.push_back(mk("wrap_num8",  0, 3'd0, 4'd0, 32'd0, 0, 4'd8, 0, 1, run_at(0, 1, 0)));
    rows.push_back(mk("abort_run",  0, 3'd0, 4'd0, 32'd0, 0, 4'd8, 1, 0, idle_at(0, 1)));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask

`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
  task automatic test_loop_limit();
    row_t rows[$];
    snap_t e;
    string nm;
    rows.push_back(mk("lim_start",      0, 3'd0, 4'd0, 32'd0, 1, 4'd2, 0, 0, run_at(0, 0, 1), 16'd2));
    rows.push_back(mk("lim_sw1",        0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 0, 1, run_at(1, 0, 0), 16'd2));
    rows.push_back(mk("lim_sw2",        0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 0, 1, run_at(0, 1, 0), 16'd2));
    rows.push_back(mk("lim_sw3",        0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 0, 1, run_at(1, 1, 0), 16'd2));
    rows.push_back(mk("lim_done",       0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 0, 1, done_at(2), 16'd2));
    rows.push_back(mk("done_sw_ignore", 0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 0, 1, done_at(2), 16'd2));
    rows.push_back(mk("lim0_start",     0, 3'd0, 4'd0, 32'd0, 1, 4'd2, 0, 0, run_at(0, 0, 1), 16'd0));
    for (int k = 1; k <= 6; k++)
      rows.push_back(mk("lim0_unbounded", 0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 0, 1,
                        run_at(k % 2, 16'(k / 2), 0), 16'd0));
    rows.push_back(mk("lim0_abort",     0, 3'd0, 4'd0, 32'd0, 0, 4'd2, 1, 0, idle_at(0, 3), 16'd0));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask
`endif

  task automatic test_async_reset();
    row_t rows[$];
    row_t post[$];
    snap_t e;
    string nm;
    rows.push_back(mk("pre_rst_start", 0, 3'd0, 4'd0, 32'd0, 1, 4'd3, 0, 0, run_at(0, 0, 1)));
    rows.push_back(mk("pre_rst_sw",    0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 1, run_at(1, 0, 0)));
    foreach (rows[i]) begin
      exp_q.push_back(rows[i].exp); name_q.push_back(rows[i].nm);
      drive(rows[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
    #2 reset_n = 1'b0;
    #1;
    exp_q.push_back(idle_at(0, 0)); name_q.push_back("async_reset_clear");
    e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
    else $display("ok   %s: %h", nm, obs);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin m_op[i] = '0; m_cst[i] = '0; end
    post.push_back(mk("post_rst_ctx0", 0, 3'd0, 4'd0, 32'd0, 1, 4'd3, 0, 0, run_at(0, 0, 1)));
    post.push_back(mk("post_rst_ctx1", 0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 1, run_at(1, 0, 0)));
    post.push_back(mk("post_rst_ctx2", 0, 3'd0, 4'd0, 32'd0, 0, 4'd3, 0, 1, run_at(2, 0, 0)));
    foreach (post[i]) begin
      exp_q.push_back(post[i].exp); name_q.push_back(post[i].nm);
      drive(post[i]);
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, e); end
      else $display("ok   %s: %h", nm, obs);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_run_guard();
    test_bad_start();
    test_write_start();
`ifdef ELASTIC_CONTEXT_LOOP_LIMIT_EN
    test_loop_limit();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_context_controller.md
# elastic_context_controller

Context sequencer for one elastic PE. It stores a small table of configuration contexts (operation code plus constant) and drives the `op`/`const_data` inputs of the PE's elastic ALU. It raises the ALU's `start_exec` once per run and advances to the next context each time the ALU reports `switch_context`, which happens on an output transfer. It sits between the global configuration loader and the ALU.

## Interface
- `DATA_WIDTH`, default 32: width of the constant field.
- `OPERATION_BIT_LENGTH`, default 4: width of the op code.
- `CONTEXT_NUM`, default 8: context table depth; must be ≥ 2.
- `CTX_ADDR_WIDTH`, default 3: equals clog2(CONTEXT_NUM).
- `LOOP_WIDTH`, default 16: width of the iteration counter and the loop limit.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `config_write` in 1: writes one context entry.
- `config_addr` in CTX_ADDR_WIDTH: entry index.
- `config_op` in OPERATION_BIT_LENGTH: op code to store.
- `config_const` in DATA_WIDTH: constant to store.
- `config_context_num` in CTX_ADDR_WIDTH+1: number of active contexts; sampled on start.
- `config_loop_limit` in LOOP_WIDTH: number of table passes; sampled on start. Present only with the macro (see Configuration).
- `start` in 1: 1-cycle request to begin a run.
- `abort` in 1: forces a return to IDLE.
- `switch_context` in 1: pulse from the ALU.
- `op` out OPERATION_BIT_LENGTH: op code to the ALU.
- `const_data` out DATA_WIDTH: constant to the ALU.
- `start_exec` out 1: 1-cycle start pulse to the ALU.
- `context_id` out CTX_ADDR_WIDTH: current table pointer.
- `iteration_count` out LOOP_WIDTH: completed table passes.
- `running` out 1: high in RUN.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, RUN, DONE.
- Context table: CONTEXT_NUM entries of {op, const}. Reset clears every entry to {0, 0}.
- `config_write` takes effect only in IDLE or DONE; it is ignored in RUN.
- `config_addr` ≥ CONTEXT_NUM: the write is ignored.
- `start` is accepted in IDLE or DONE only if 1 ≤ `config_context_num` ≤ CONTEXT_NUM. Otherwise it is ignored and the state is unchanged.
- On an accepted start:
  - latch `num_ctx` (and the loop limit when the macro is defined);
  - set `context_id` to 0 and `iteration_count` to 0;
  - state goes to RUN.
- In RUN, `op` and `const_data` are combinational reads of table[`context_id`].
- Outside RUN, `op` and `const_data` are 0 (NOP).
- `switch_context` in RUN:
  - if `context_id` = num_ctx-1: `context_id` goes to 0 and `iteration_count` increments;
  - otherwise `context_id` increments.
- `switch_context` outside RUN is ignored.
- `iteration_count` wraps modulo 2^LOOP_WIDTH.
- `abort` moves any state to IDLE and clears `context_id`. `iteration_count` holds its value.
- Priority within one cycle: `abort` > `start` > `switch_context`.
- `start` while in RUN is ignored.
- DONE holds the final `context_id` = 0 and `iteration_count` until the next start or an abort.

## Timing
- Reset values: state IDLE, `op` 0, `const_data` 0, `start_exec` 0, `context_id` 0, `iteration_count` 0, `running` 0, `done` 0.
- `start_exec` is registered. It is high for exactly the one cycle after `start` is accepted, i.e. the first cycle of RUN. It is never asserted otherwise.
- `context_id`, `op` and `const_data` update in the cycle after `switch_context` is sampled. The ALU returns to its before-exec state in that same cycle, so the new op is presented before the next input transfer.
- A `config_write` and an accepted `start` in the same cycle: the write commits, and the new entry is visible in RUN's first cycle.
- A `switch_context` on every consecutive cycle must advance one entry per cycle with no drops.
- Deasserting `reset_n` mid-run returns all state to the reset values immediately (asynchronous) and clears the table.

## Configuration
Macro: `ELASTIC_CONTEXT_LOOP_LIMIT_EN`.

With the macro defined:
- the `config_loop_limit` port exists;
- on a wrap where `iteration_count`+1 equals the latched limit, the state goes to DONE in the same edge and `iteration_count` is updated;
- a latched limit of 0 is treated as unbounded.

Without the macro:
- no `config_loop_limit` port;
- RUN loops forever, and only `abort` or reset leaves it;
- `done` is tied to 0.

## Test plan
- Reset, then read the outputs: all are 0, state IDLE, and `op` = 0 even with the table holding data.
- Write entries 0..2 = {1,0}, {5,7}, {8,0}; context_num = 3; start. Then:
  - `start_exec` is high 1 cycle later;
  - `op` = 1 in RUN's first cycle;
  - successive `switch_context` pulses produce `op` 5 (const 7), then 8, then 1 again with `iteration_count` = 1.
- Start with context_num = 0, and again with context_num = 9 (CONTEXT_NUM = 8): both are ignored; `running` stays 0 and there is no `start_exec`.
- In RUN, `config_write` to entry 1 with op 3: the table is unchanged and `op` still reads 5 at context 1. Also assert `start` and `abort` together: the result is IDLE with `op` = 0.
- With the macro, limit = 2 and context_num = 2: after 4 `switch_context` pulses, `done` = 1, `iteration_count` = 2 and `running` = 0. Further `switch_context` pulses change nothing.
- Drop `reset_n` mid-RUN: the outputs clear asynchronously, and after reset the table reads 0.
